// File: rtl/micro_sequencer.sv
// micro_sequencer: next-address controller for the microprogrammed control
// unit. Owns the control address register (CAR), the T-step counter, the
// micro-return stack and RUN/HALT handling.
//
// Interface timing: seq_op/seq_target/cond_* are combinational from the
// microword at the current car. Every state change lands on the next rising
// edge, so each microword executes for exactly one cycle. All outputs are
// taken straight from registers, with no input-to-output combinational path.
module micro_sequencer #(
  parameter int CADDR_WIDTH  = 10,
  parameter int OPCODE_WIDTH = 8,
  parameter int FETCH_ADDR   = 0,
  parameter int MAP_OFFSET   = 4,
  parameter int STACK_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hlt,
  input  logic [2:0]              seq_op,
  input  logic [CADDR_WIDTH-1:0]  seq_target,
  input  logic [1:0]              cond_sel,
  input  logic                    cond_inv,
  input  logic [3:0]              status,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic [CADDR_WIDTH-1:0]  car,
  output logic [3:0]              T,
  output logic                    halted,
  output logic                    ctrl_en,
  output logic                    stack_err
);

  // The pointer needs one extra bit so that "full" (== STACK_DEPTH) is representable.
  localparam int IW = $clog2(STACK_DEPTH);
  localparam int PW = IW + 1;
  localparam logic [CADDR_WIDTH-1:0] FETCH_CAR = CADDR_WIDTH'(FETCH_ADDR);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    OP_NEXT   = 3'd0,
    OP_JUMP   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_MAP    = 3'd3,
    OP_FETCH  = 3'd4,
    OP_CALL   = 3'd5,
    OP_RET    = 3'd6,
    OP_HOLD   = 3'd7
  } seq_op_t;

  state_t                 state_q, state_d;
  logic [CADDR_WIDTH-1:0] car_q, car_d;
  logic [3:0]             t_q, t_d;
  logic [PW-1:0]          sp_q, sp_d;
  logic                   stack_err_q, stack_err_d;
  logic [CADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [CADDR_WIDTH-1:0] stack_d [STACK_DEPTH];

  logic [CADDR_WIDTH-1:0] car_inc;
  logic [3:0]             t_sat;
  logic                   stack_full;
  logic                   stack_empty;
  logic [IW-1:0]          top_idx;
  logic                   cond;

  // Shared helpers: wrapped increment, saturating T step, stack status, branch condition.
  always_comb begin
    car_inc     = car_q + CADDR_WIDTH'(1);
    t_sat       = (t_q == 4'hF) ? t_q : t_q + 4'd1;
    stack_full  = (sp_q == PW'(STACK_DEPTH));
    stack_empty = (sp_q == '0);
    top_idx     = IW'(sp_q - PW'(1));
    cond        = status[cond_sel] ^ cond_inv;
  end

  // Next-state, next-address, T counter and stack update.
  always_comb begin
    state_d     = state_q;
    car_d       = car_q;
    t_d         = t_q;
    sp_d        = sp_q;
    stack_err_d = stack_err_q;
    stack_d     = stack_q;
    case (state_q)
      ST_RUN: begin
        case (seq_op_t'(seq_op))
          OP_NEXT: begin
            car_d = car_inc;
            t_d   = t_sat;
          end
          OP_JUMP: begin
            car_d = seq_target;
            t_d   = t_sat;
          end
          OP_BRANCH: begin
            car_d = cond ? seq_target : car_inc;
            t_d   = t_sat;
          end
          OP_MAP: begin
            // Zero-extend the opcode, add the ROM base, and wrap to the CAR width.
            car_d = CADDR_WIDTH'(opcode) + CADDR_WIDTH'(MAP_OFFSET);
            t_d   = t_sat;
          end
          OP_FETCH: begin
            car_d = FETCH_CAR;
            t_d   = 4'd0;
            // hlt is only honoured here, so the current instruction always completes.
            if (hlt) state_d = ST_HALT;
          end
          OP_CALL: begin
            t_d = t_sat;
            if (!stack_full) begin
              stack_d[sp_q[IW-1:0]] = car_inc;
              sp_d                  = sp_q + PW'(1);
              car_d                 = seq_target;
            end else begin
              car_d       = car_inc;
              stack_err_d = 1'b1;
            end
          end
          OP_RET: begin
            if (!stack_empty) begin
              car_d = stack_q[top_idx];
              sp_d  = sp_q - PW'(1);
              t_d   = t_sat;
            end else begin
              // Underflow restarts the instruction cycle.
              car_d       = FETCH_CAR;
              t_d         = 4'd0;
              stack_err_d = 1'b1;
            end
          end
          OP_HOLD: begin
            car_d = car_q;
            t_d   = t_q;
          end
          default: begin
            car_d = car_q;
            t_d   = t_q;
          end
        endcase
      end
      ST_HALT: begin
        // Park on the fetch routine and keep the stack as it is.
        car_d = FETCH_CAR;
        t_d   = 4'd0;
        if (!hlt) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        car_d   = FETCH_CAR;
        t_d     = 4'd0;
      end
    endcase
  end

  // State registers; synchronous reset has priority and empties the stack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      car_q       <= FETCH_CAR;
      t_q         <= 4'd0;
      sp_q        <= '0;
      stack_err_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      car_q       <= car_d;
      t_q         <= t_d;
      sp_q        <= sp_d;
      stack_err_q <= stack_err_d;
      stack_q     <= stack_d;
    end
  end

  // Outputs are direct decodes of registered state.
  always_comb begin
    car       = car_q;
    T         = t_q;
    halted    = (state_q == ST_HALT);
    ctrl_en   = (state_q != ST_HALT);
    stack_err = stack_err_q;
  end

endmodule
